serial_parity_frame_checker: RTL and testbench
==============================================

Name: serial_parity_frame_checker

Overview:
- Parametrised serial parity checker. Receives a framed bit stream of DATA_BITS data bits followed by one parity bit.
- Provides a running Mealy parity indication per bit, a per-frame pass/fail result with even or odd mode, a frame-abort report and a saturating error counter.
- Sits behind the serial receive path and feeds link-status logic.

Parameters:
- DATA_BITS, 8, data bits per frame excluding the parity bit; legal range >= 1.
- ERR_CNT_W, 8, width of the saturating parity-error counter; legal range >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset.
- i_valid  input  1  qualifies i_x and i_sof this cycle; low = stall.
- i_x  input  1  serial bit.
- i_sof  input  1  with i_valid, marks i_x as data bit 0 of a new frame.
- i_odd_mode  input  1  0 = even parity, 1 = odd parity; sampled at the SOF beat.
- o_p  output  1  combinational Mealy running-parity flag.
- o_busy  output  1  high while a frame is in progress (state != IDLE).
- o_frame_done  output  1  registered one-cycle pulse after the parity bit is accepted.
- o_parity_err  output  1  registered; valid with o_frame_done, otherwise 0.
- o_abort  output  1  registered one-cycle pulse when an in-progress frame is cut short by SOF.
- o_err_cnt  output  ERR_CNT_W  saturating count of failed frames.

Behaviour:
- Reset: rst is synchronous, active-high, and overrides all other inputs.
  - State = IDLE; internal parity accumulator par = 0; bit counter = 0; latched mode = 0.
  - o_frame_done = 0, o_parity_err = 0, o_abort = 0, o_err_cnt = 0.
  - Reset mid-frame discards the frame silently: no done, no abort, no count.
- A beat is i_valid = 1 on a rising edge. When i_valid = 0, all state holds and no pulse is generated.
- States: IDLE, DATA, CHECK.
  - IDLE: a beat with i_sof = 1 → DATA. par <= i_x, cnt <= 1, mode latched from i_odd_mode. If DATA_BITS == 1, go directly to CHECK. A beat with i_sof = 0 is ignored.
  - DATA: a beat with i_sof = 0 → par <= par ^ i_x, cnt <= cnt + 1. When cnt reaches DATA_BITS, go to CHECK.
  - CHECK: a beat with i_sof = 0 is the parity bit.
    - Total = par ^ i_x.
    - Even mode: error iff total = 1. Odd mode: error iff total = 0.
    - Next cycle: o_frame_done = 1 and o_parity_err = error.
    - On error, o_err_cnt increments and saturates at 2^ERR_CNT_W - 1.
    - State → IDLE, par <= 0, cnt <= 0.
- SOF while in DATA or CHECK: the current frame is aborted.
  - o_abort pulses next cycle; no frame_done is generated.
  - The beat starts a new frame exactly as the IDLE SOF case, latching the new mode.
- o_p (combinational, zero latency): o_p = ~(par_eff ^ (i_valid & i_x)) ^ mode_eff.
  - In even mode, o_p = 1 means an even count of ones so far in the frame, including the current bit.
  - par_eff = 0 in IDLE or on an SOF beat; otherwise par_eff = par.
  - mode_eff = i_odd_mode in IDLE or on an SOF beat; otherwise the latched mode.
  - In CHECK, o_p reflects the whole frame including the parity bit.
- o_frame_done and o_abort are never high in the same cycle.
- Bit counter width = $clog2(DATA_BITS + 1).

Decomposition:
- Package serial_parity_pkg: state enum (IDLE, DATA, CHECK); localparams for mode encoding (MODE_EVEN = 0, MODE_ODD = 1).
- One sub-module, sat_counter: parametrised width, increment enable, synchronous reset, saturation. It implements o_err_cnt.

Test Plan:
- Even, pass: DATA_BITS = 4, even; SOF beat 1, then 0, 1, 1, parity 1 → o_frame_done = 1, o_parity_err = 0, o_err_cnt = 0. o_p per beat = 0, 0, 1, 0, 1.
- Even, fail: same data with parity 0 → o_parity_err = 1, o_err_cnt = 1. Odd mode: data 1, 0, 0, 0 with parity 0 → o_parity_err = 0.
- Stall: frame from the pass case with i_valid = 0 for 3 cycles between every beat (i_x toggling during stalls) → identical result; o_busy stays high throughout the gaps.
- Abort: SOF, 1, 0, then SOF with 1 on the third beat → o_abort pulses once. A further 1, 1, 1 plus parity 0 completes the new frame with o_parity_err = 0 (four ones).
- Saturation: ERR_CNT_W = 2; five consecutive failing frames → o_err_cnt goes 1, 2, 3, 3, 3.
- Reset mid-frame: rst asserted after 2 data beats → o_busy = 0 and no pulses. A subsequent full passing frame completes normally with o_err_cnt = 0. Beats without SOF while in IDLE produce no response.

Source files
------------

// File: rtl/serial_parity_pkg.sv
// Shared types for the serial parity frame checker.
//   state_t   : frame FSM state (IDLE, DATA, CHECK)
//   MODE_EVEN / MODE_ODD : encoding of the latched parity mode bit
package serial_parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count enable; ignored once the counter is all ones
//   cnt      : current count, W bits
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/serial_parity_frame_checker.sv
// Serial parity frame checker: DATA_BITS data bits followed by one parity bit.
//   clk, rst      : clock, synchronous active-high reset
//   i_valid       : beat qualifier (low = stall, all state holds)
//   i_x           : serial bit
//   i_sof         : with i_valid, i_x is data bit 0 of a new frame
//   i_odd_mode    : 0 even / 1 odd parity, latched on the SOF beat
//   o_p           : combinational running-parity flag (includes current bit)
//   o_busy        : frame in progress
//   o_frame_done  : one-cycle pulse after the parity bit is accepted
//   o_parity_err  : frame result, qualified by o_frame_done
//   o_abort       : one-cycle pulse when an SOF cuts a frame short
//   o_err_cnt     : saturating count of failed frames
module serial_parity_frame_checker
  import serial_parity_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_x,
  input  logic                 i_sof,
  input  logic                 i_odd_mode,
  output logic                 o_p,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_parity_err,
  output logic                 o_abort,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int              CW       = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DATA_BITS);

  state_t        state, state_n;
  logic          par, par_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          mode, mode_n;
  logic          done_n, err_n, abort_n;
  logic          total, err_inc;
  logic          sof_beat, par_eff, mode_eff;

  assign sof_beat = i_valid & i_sof;
  assign cnt_inc  = cnt + 1'b1;
  assign o_busy   = (state != IDLE);

  // A new frame starts from a clean accumulator, so IDLE and SOF beats
  // ignore the stored parity and use the incoming mode directly.
  assign par_eff  = (state == IDLE || sof_beat) ? 1'b0 : par;
  assign mode_eff = (state == IDLE || sof_beat) ? i_odd_mode : mode;
  assign o_p      = ~(par_eff ^ (i_valid & i_x)) ^ mode_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      par          <= 1'b0;
      cnt          <= '0;
      mode         <= MODE_EVEN;
      o_frame_done <= 1'b0;
      o_parity_err <= 1'b0;
      o_abort      <= 1'b0;
    end else begin
      state        <= state_n;
      par          <= par_n;
      cnt          <= cnt_n;
      mode         <= mode_n;
      o_frame_done <= done_n;
      o_parity_err <= err_n;
      o_abort      <= abort_n;
    end
  end

  always_comb begin
    state_n = state;
    par_n   = par;
    cnt_n   = cnt;
    mode_n  = mode;
    done_n  = 1'b0;
    err_n   = 1'b0;
    abort_n = 1'b0;
    err_inc = 1'b0;
    total   = par ^ i_x;
    if (i_valid) begin
      if (i_sof) begin
        // SOF always (re)starts a frame; anything in flight is dropped.
        abort_n = (state != IDLE);
        par_n   = i_x;
        cnt_n   = CW'(1);
        mode_n  = i_odd_mode;
        state_n = (DATA_BITS == 1) ? CHECK : DATA;
      end else begin
        case (state)
          DATA: begin
            par_n = par ^ i_x;
            cnt_n = cnt_inc;
            if (cnt_inc == LAST_CNT) state_n = CHECK;
          end
          CHECK: begin
            done_n  = 1'b1;
            err_n   = (mode == MODE_ODD) ? ~total : total;
            err_inc = err_n;
            par_n   = 1'b0;
            cnt_n   = '0;
            state_n = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Reset has priority inside the counter, so a frame finishing on a
  // reset edge is never counted.
  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .cnt (o_err_cnt)
  );

endmodule

// File: tb/tb_serial_parity_frame_checker.sv
module tb_serial_parity_frame_checker;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst, i_valid, i_x, i_sof, i_odd_mode;
  logic       o_p, o_busy, o_frame_done, o_parity_err, o_abort;
  logic [7:0] o_err_cnt;
  logic       p2, busy2, done2, perr2, abort2;
  logic [1:0] o_err_cnt2;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit         in_frame;
  bit         fmode;
  bit         fbits[$];
  logic       exp_p, obs_p, exp_done, exp_err, exp_abort, exp_busy;
  logic [7:0] exp_cnt;
  logic [1:0] exp_cnt2;

  always #5 clk = ~clk;

  serial_parity_frame_checker #(.DATA_BITS(DB), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_x(i_x), .i_sof(i_sof),
    .i_odd_mode(i_odd_mode), .o_p(o_p), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_parity_err(o_parity_err),
    .o_abort(o_abort), .o_err_cnt(o_err_cnt)
  );

  serial_parity_frame_checker #(.DATA_BITS(DB), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_x(i_x), .i_sof(i_sof),
    .i_odd_mode(i_odd_mode), .o_p(p2), .o_busy(busy2),
    .o_frame_done(done2), .o_parity_err(perr2),
    .o_abort(abort2), .o_err_cnt(o_err_cnt2)
  );

  function automatic int ones_in_frame();
    int n = 0;
    foreach (fbits[i]) n += int'(fbits[i]);
    return n;
  endfunction

  function automatic logic [14:0] obs_vec();
    return {obs_p, o_busy, o_frame_done, o_parity_err, o_abort, o_err_cnt, o_err_cnt2};
  endfunction

  function automatic logic [14:0] exp_vec();
    return {exp_p, exp_busy, exp_done, exp_err, exp_abort, exp_cnt, exp_cnt2};
  endfunction

  // One clock: drive inputs, sample o_p before the edge, advance the model
  // across the edge, leave registered outputs settled for the caller.
  task automatic step(input bit r, input bit v, input bit s, input bit x, input bit odd);
    int  ones;
    bit  new_frame, e;
    rst = r; i_valid = v; i_sof = s; i_x = x; i_odd_mode = odd;
    #1;
    new_frame = (v && s) || !in_frame;
    ones  = (new_frame ? 0 : ones_in_frame()) + int'(v && x);
    exp_p = ((ones % 2) == 0) ^ (new_frame ? odd : fmode);
    obs_p = o_p;
    @(posedge clk);
    exp_done = 0; exp_err = 0; exp_abort = 0;
    if (r) begin
      in_frame = 0; fbits.delete(); fmode = 0; exp_cnt = 0; exp_cnt2 = 0;
    end else if (v) begin
      if (s) begin
        exp_abort = in_frame;
        fbits.delete(); fbits.push_back(x);
        fmode = odd; in_frame = 1;
      end else if (in_frame) begin
        if (fbits.size() < DB) fbits.push_back(x);
        else begin
          ones = ones_in_frame() + int'(x);
          e = fmode ? ((ones % 2) == 0) : ((ones % 2) == 1);
          exp_done = 1; exp_err = e;
          if (e && exp_cnt != 8'hFF) exp_cnt++;
          if (e && exp_cnt2 != 2'd3) exp_cnt2++;
          in_frame = 0; fbits.delete();
        end
      end
    end
    exp_busy = in_frame;
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    checks++;
    if ({o_busy, o_frame_done, o_parity_err, o_abort, o_err_cnt, o_err_cnt2} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state got=%b want=0", {o_busy, o_frame_done, o_parity_err, o_abort, o_err_cnt, o_err_cnt2});
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_even_pass();
    bit xs[5] = '{1, 0, 1, 1, 1};
    bit pe[5] = '{0, 0, 1, 0, 1};
    for (int i = 0; i < 5; i++) begin
      step(0, 1, i == 0, xs[i], 0);
      checks++;
      if (obs_p !== pe[i]) begin errors++; $display("FAIL even_pass_p beat=%0d got=%b want=%b", i, obs_p, pe[i]); end
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL even_pass_model beat=%0d got=%b want=%b", i, obs_vec(), exp_vec()); end
    end
    checks++;
    if ({o_frame_done, o_parity_err, o_err_cnt} !== {1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL even_pass_result got=%b%b cnt=%0d want done=1 err=0 cnt=0", o_frame_done, o_parity_err, o_err_cnt);
    end
  endtask

  task automatic test_fail_and_odd();
    bit xs[5] = '{1, 0, 1, 1, 0};
    bit xo[5] = '{1, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      step(0, 1, i == 0, xs[i], 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL even_fail_model beat=%0d got=%b want=%b", i, obs_vec(), exp_vec()); end
    end
    checks++;
    if ({o_frame_done, o_parity_err, o_err_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      errors++; $display("FAIL even_fail_result got=%b%b cnt=%0d want done=1 err=1 cnt=1", o_frame_done, o_parity_err, o_err_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, i == 0, xo[i], 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL odd_model beat=%0d got=%b want=%b", i, obs_vec(), exp_vec()); end
    end
    checks++;
    if ({o_frame_done, o_parity_err, o_err_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      errors++; $display("FAIL odd_result got=%b%b cnt=%0d want done=1 err=0 cnt=1", o_frame_done, o_parity_err, o_err_cnt);
    end
  endtask

  task automatic test_stall();
    bit xs[5] = '{1, 0, 1, 1, 1};
    for (int i = 0; i < 5; i++) begin
      step(0, 1, i == 0, xs[i], 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL stall_beat beat=%0d got=%b want=%b", i, obs_vec(), exp_vec()); end
      if (i < 4) for (int k = 0; k < 3; k++) begin
        step(0, 0, 0, k[0], 1);
        checks++;
        if (obs_vec() !== exp_vec() || o_busy !== 1'b1) begin
          errors++; $display("FAIL stall_gap beat=%0d got=%b want=%b", i, obs_vec(), exp_vec());
        end
      end
    end
    checks++;
    if ({o_frame_done, o_parity_err} !== 2'b10) begin
      errors++; $display("FAIL stall_result got=%b want=10", {o_frame_done, o_parity_err});
    end
  endtask

  task automatic test_abort();
    bit xs[8] = '{1, 0, 1, 1, 1, 1, 0, 0};
    bit ss[8] = '{1, 0, 1, 0, 0, 0, 0, 0};
    int aborts = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 1, ss[i], xs[i], 0);
      aborts += int'(o_abort);
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL abort_model beat=%0d got=%b want=%b", i, obs_vec(), exp_vec()); end
      if (i == 2) begin
        checks++;
        if (o_abort !== 1'b1 || o_frame_done !== 1'b0) begin
          errors++; $display("FAIL abort_pulse got abort=%b done=%b want abort=1 done=0", o_abort, o_frame_done);
        end
      end
    end
    checks++;
    if (aborts != 1 || {o_frame_done, o_parity_err} !== 2'b10) begin
      errors++; $display("FAIL abort_newframe got aborts=%0d done/err=%b want aborts=1 done/err=10", aborts, {o_frame_done, o_parity_err});
    end
  endtask

  task automatic test_saturation();
    bit xs[5] = '{1, 0, 1, 1, 0};
    logic [1:0] want[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    step(1, 0, 0, 0, 0);
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 5; i++) begin
        step(0, 1, i == 0, xs[i], 0);
        checks++;
        if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL sat_model frame=%0d beat=%0d got=%b want=%b", f, i, obs_vec(), exp_vec()); end
      end
      checks++;
      if (o_err_cnt2 !== want[f] || o_err_cnt !== 8'(f + 1)) begin
        errors++; $display("FAIL sat_count frame=%0d got=%0d/%0d want=%0d/%0d", f, o_err_cnt2, o_err_cnt, want[f], f + 1);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit xs[5] = '{0, 1, 1, 0, 0};
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    checks++;
    if ({o_busy, o_frame_done, o_abort, o_err_cnt} !== 11'd0) begin
      errors++; $display("FAIL reset_mid got busy=%b done=%b abort=%b cnt=%0d want all 0", o_busy, o_frame_done, o_abort, o_err_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, i[0], i[1]);
      checks++;
      if (obs_vec() !== exp_vec() || o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
        errors++; $display("FAIL idle_ignore beat=%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, i == 0, xs[i], 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL post_reset_model beat=%0d got=%b want=%b", i, obs_vec(), exp_vec()); end
    end
    checks++;
    if ({o_frame_done, o_parity_err, o_err_cnt} !== {1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL post_reset_result got=%b%b cnt=%0d want done=1 err=0 cnt=0", o_frame_done, o_parity_err, o_err_cnt);
    end
  endtask

  task automatic test_random();
    bit r, v, s;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(99) < 2);
      v = ($urandom_range(99) < 75);
      s = ($urandom_range(99) < 12);
      step(r, v, s, 1'($urandom), 1'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL random i=%0d got=%b want=%b", i, obs_vec(), exp_vec()); end
      checks++;
      if (o_frame_done && o_abort) begin errors++; $display("FAIL done_abort_excl i=%0d got=11 want not both", i); end
    end
  endtask

  initial begin
    rst = 1; i_valid = 0; i_x = 0; i_sof = 0; i_odd_mode = 0;
    in_frame = 0; fmode = 0;
    exp_cnt = 0; exp_cnt2 = 0; exp_done = 0; exp_err = 0; exp_abort = 0; exp_busy = 0;
    exp_p = 0; obs_p = 0;
    @(posedge clk); #1;
    test_reset();
    test_even_pass();
    test_fail_and_odd();
    test_stall();
    test_abort();
    test_saturation();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
